lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit for the RV32I core, driving the data port of the synchronous I/D RAM.
// One request in flight, fixed turnaround: accept, access, capture, respond.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_we,
  output logic [3:0]            d_be,
  output logic [31:0]           d_wdata,
  input  logic [31:0]           d_rdata
);

  // state   | meaning
  // IDLE    | ready; accept a request and set up the RAM port
  // ACCESS  | address, enables and data on the RAM port; RAM samples at cycle end
  // CAPTURE | registered RAM data valid; format it into resp_rdata
  // RESP    | resp_valid pulse, then back to IDLE
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt;

  // Bits above the RAM size are dropped so the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // funct3[1:0] is the access size; funct3[2] is the unsigned flag, legal only on byte/half loads.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_funct3[2] && (req_we || req_funct3[1]))
      req_err = 1'b1;
  end

  always_comb begin
    req_be   = 4'b0000;
    req_wrep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'b10:   req_be = 4'b1111;
      default: req_be = 4'b0000;
    endcase
    if (req_err)
      req_be = 4'b0000;
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = d_rdata[7:0];
      2'd1:    ld_byte = d_rdata[15:8];
      2'd2:    ld_byte = d_rdata[23:16];
      default: ld_byte = d_rdata[31:24];
    endcase
    ld_half  = off_q[1] ? d_rdata[31:16] : d_rdata[15:0];
    load_fmt = 32'h0;
    if (!we_q && !err_q) begin
      case (funct3_q)
        3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  load_fmt = {24'h0, ld_byte};
        3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
        3'b101:  load_fmt = {16'h0, ld_half};
        3'b010:  load_fmt = d_rdata;
        default: load_fmt = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      err_q      <= 1'b0;
      d_addr     <= '0;
      d_we       <= 1'b0;
      d_be       <= 4'b0000;
      d_wdata    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            err_q    <= req_err;
            d_addr   <= req_addr[ADDR_WIDTH+1:2];
            d_be     <= req_be;
            d_wdata  <= req_wrep;
            d_we     <= req_we && !req_err;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          d_we  <= 1'b0;
          d_be  <= 4'b0000;
          state <= CAPTURE;
        end
        CAPTURE: begin
          resp_rdata <= load_fmt;
          resp_err   <= err_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: RAM model on the data port, directed requests, queued expected responses.
module tb_lsu_mem_port;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata = 32'h0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  lsu_mem_port #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read-first, registered read, per-lane write enables, never reset.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem.exists(int'(d_addr)) ? mem[int'(d_addr)] : 32'h0;
    d_rdata <= w;
    if (d_we) begin
      for (int k = 0; k < 4; k++)
        if (d_be[k]) w[8*k +: 8] = d_wdata[8*k +: 8];
      mem[int'(d_addr)] = w;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_latency", cyc - e.acc, 32'd3);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    wait_ready();
    if (!req_ready) return;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    e.rd = exp_rd; e.err = exp_err; e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("access_d_addr", {17'h0, d_addr}, {17'h0, addr[AW+1:2]});
    chk("access_d_we", {31'h0, d_we}, {31'h0, we && !exp_err});
    if (!exp_err) chk("access_d_be", {28'h0, d_be}, {28'h0, exp_be});
    if (!exp_err && we) chk("access_d_wdata", d_wdata, exp_wd);
    @(negedge clk);
    chk("capture_d_we", {31'h0, d_we}, 32'h0);
    chk("capture_d_be", {28'h0, d_be}, 32'h0);
  endtask

  initial begin
    int n, nacc, last;
    exp_t e;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
    chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("idle_d_we", {31'h0, d_we}, 32'h0);
    chk("idle_d_be", {28'h0, d_be}, 32'h0);
    chk("idle_d_addr", {17'h0, d_addr}, 32'h0);
    chk("idle_d_wdata", d_wdata, 32'h0);
    chk("idle_resp_rdata", resp_rdata, 32'h0);
    chk("idle_resp_err", {31'h0, resp_err}, 32'h0);

    //     we    f3      addr          wdata         exp_rd        err   be       exp_wd
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0);
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5_A5A5);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'hFFFF_FFA5, 1'b0, 4'b1000, 32'h0);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h0000_00A5, 1'b0, 4'b1000, 32'h0);
    issue(1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'hFFFF_FFEF, 1'b0, 4'b0001, 32'h0);
    issue(1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344, 32'h0,        1'b0, 4'b1111, 32'h1122_3344);
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_8001, 32'h0,        1'b0, 4'b1100, 32'h8001_8001);
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h8001_3344, 1'b0, 4'b1111, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'hFFFF_8001, 1'b0, 4'b1100, 32'h0);
    issue(1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h0000_8001, 1'b0, 4'b1100, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_0200, 32'h0,        32'h0000_3344, 1'b0, 4'b0011, 32'h0);
    issue(1'b0, 3'b000, 32'h0000_0201, 32'h0,        32'h0000_0033, 1'b0, 4'b0010, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0,        1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hA5AD_BEEF, 1'b0, 4'b1111, 32'h0);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0055, 32'h0,        1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h8000_0100, 32'h0,        32'hA5AD_BEEF, 1'b0, 4'b1111, 32'h0);

    // Reset during CAPTURE of a load: no response may come out.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_req_ready_low", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (5) @(negedge clk);

    // req_valid held high: one accept every 4 cycles.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    nacc = 0; last = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) begin
        e.rd = 32'hA5AD_BEEF; e.err = 1'b0; e.acc = cyc;
        exp_q.push_back(e);
        if (nacc > 0) chk("accept_spacing", i - last, 32'd4);
        last = i;
        nacc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("accept_count", nacc, 32'd3);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pending_responses", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
